csr_unit: RTL and testbench
===========================

# csr_unit

Machine-mode CSR file for the pipelined core, successor to the single-port CSR register bank. Reads are served to ID. Read-modify-write CSR instructions commit from EX. Trap entry and `mret` update `mstatus`/`mepc`/`mcause` atomically. The block adds `mip` sampling, prioritised interrupt requests, direct/vectored `mtvec`, and 64-bit `mcycle`/`minstret` counters.

## Interface
- `CNT_W`, 64: counter width; legal range 33..64, upper half read as `CNT_W-32` bits zero-extended.
- `VECTORED_EN`, 1: honour `mtvec.MODE=1`; when 0, MODE reads 0 and writes to it are ignored.
- `MTVEC_RESET`, 32'h0: `mtvec` reset value.
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `csr_ra_id` in 12: ID read address.
- `csr_rd` out 32: read data, combinational from current state.
- `csr_rd_illegal` out 1: `csr_ra_id` unmapped.
- `csr_we_ex` in 1: commit CSR op.
- `csr_op_ex` in 2: 01 RW, 10 RS (set), 11 RC (clear), 00 no-op.
- `csr_wa_ex` in 12: write address.
- `csr_wd_ex` in 32: source operand (rs1 or zimm, already extended).
- `retire` in 1: one instruction retired this cycle.
- `irq` in 3: {external, timer, software} level inputs.
- `trap_valid` in 1: take trap this cycle.
- `trap_is_irq` in 1: trap is an interrupt.
- `trap_code` in 5: exception or interrupt code.
- `trap_pc` in 32: PC saved to `mepc`.
- `mret_valid` in 1: execute `mret`.
- `trap_target` out 32: handler PC, combinational.
- `mret_target` out 32: equals `mepc`.
- `irq_req` out 1: interrupt enabled and pending.
- `irq_code` out 5: highest-priority pending enabled interrupt code.

## Operation
- Mapped addresses: mstatus 300, mie 304, mtvec 305, mscratch 340, mepc 341, mcause 342, mip 344 (read-only), mcycle B00, mcycleh B80, minstret B02, minstreth B82.
- Any other address is unmapped. Unmapped reads return 0 with `csr_rd_illegal=1`. Unmapped writes are ignored.
- Write value: RW = wd; RS = cur | wd; RC = cur & ~wd, where cur is the current register value. Writes commit at the next edge.
- WARL fields:
  - mstatus implements only MIE[3] and MPIE[7]; MPP[12:11] reads 2'b11. All other bits read 0.
  - mie implements bits 3, 7, 11 only.
  - mepc[1:0] reads 0.
  - mtvec[1] reads 0.
  - mcause stores {interrupt bit 31, code[4:0]}.
- mip bits 11/7/3 take `irq[2]/irq[1]/irq[0]`, registered once.
- `irq_req` = mstatus.MIE & |(mie & mip).
- `irq_code` priority: external 11 > software 3 > timer 7.
- Trap entry: mepc←trap_pc, mcause←{trap_is_irq, code}, MPIE←MIE, MIE←0.
- `trap_target`:
  - Direct mode: mtvec.BASE.
  - Vectored mode with `trap_is_irq`: BASE + 4·code.
  - Exceptions always use BASE.
- `mret`: MIE←MPIE, MPIE←1.
- Counters: mcycle increments every cycle; minstret increments when `retire` is high. Both wrap from all-ones to 0.
- Writes to a low or high half replace only that half.
- Precedence at one edge: trap > mret > CSR write.
  - A CSR write colliding with a trap or mret is dropped.
  - A counter write beats that counter's increment; there is no increment that cycle.

## Timing
- Reset: mstatus=0 (MPP reads 11), mie=0, mtvec=`MTVEC_RESET`, mscratch=mepc=mcause=0, mip=0, counters=0.
- Outputs under reset: `irq_req=0`, `irq_code=0`, `trap_target=MTVEC_RESET` base, `mret_target=0`.
- Reset asserted mid-operation clears all state immediately. The first increment happens on the first edge after `rst_n` rises.
- Read latency 0: `csr_rd` reflects state before the current edge. There is no same-cycle write-to-read bypass; the pipeline handles this hazard.
- irq-to-`irq_req` latency: 1 cycle.
- Trap or mret effects are visible on the next cycle.

## Structure
- `csr_pkg` holds:
  - CSR address constants.
  - op encodings.
  - cause codes 3/7/11.
  - mstatus bit positions.
- Sub-module `csr_counter` (parameter `CNT_W`) provides increment enable, low/high write enables, write data, and a full-width value output. It is instantiated twice.

## Test plan
- Reset then read every mapped address: MSTATUS=32'h1800, MTVEC=`MTVEC_RESET`, all others 0. Read address 7C0 → 0 with `csr_rd_illegal=1`.
- RS to mie with 32'h888, then RC with 32'h8 → reads 32'h880. RW of 32'hFFFF_FFFF to mstatus → reads 32'h1888.
- MTVEC=32'h1001, mie=32'h80, MIE=1, raise `irq[1]` → `irq_req=1` and `irq_code=7` one cycle later. Trap with pc 32'h200 → `trap_target`=32'h101C, mepc=200, mcause=32'h8000_0007, MIE=0, MPIE=1.
- Assert all three irq lines with all enabled → `irq_code=11`. Drop `irq[2]` → 3.
- `trap_valid`, `mret_valid`, and a CSR write to mepc in the same cycle → trap values only.
- Write mcycle=32'hFFFF_FFFF, mcycleh=0 → next cycle reads mcycleh=1, mcycle=0. A minstret write coinciding with `retire` yields exactly the written value.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared constants for the machine-mode CSR file: addresses, op encodings,
// interrupt cause codes and mstatus field positions.
package csr_pkg;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;

  typedef enum logic [1:0] {
    CSR_OP_NOP = 2'b00,
    CSR_OP_RW  = 2'b01,
    CSR_OP_RS  = 2'b10,
    CSR_OP_RC  = 2'b11
  } csr_op_e;

  localparam logic [4:0] CAUSE_MSI = 5'd3;
  localparam logic [4:0] CAUSE_MTI = 5'd7;
  localparam logic [4:0] CAUSE_MEI = 5'd11;

  localparam int unsigned MSTATUS_MIE    = 3;
  localparam int unsigned MSTATUS_MPIE   = 7;
  localparam int unsigned MSTATUS_MPP_LO = 11;
  localparam int unsigned MSTATUS_MPP_HI = 12;

  // {external, timer, software} -> mie/mip bit layout (11/7/3)
  function automatic logic [31:0] irq_to_csr(input logic [2:0] b);
    irq_to_csr = '0;
    irq_to_csr[CAUSE_MEI] = b[2];
    irq_to_csr[CAUSE_MTI] = b[1];
    irq_to_csr[CAUSE_MSI] = b[0];
  endfunction

endpackage

// File: rtl/csr_counter.sv
// Free-running counter with independent low/high 32-bit write ports.
// A write to either half suppresses the increment for that cycle.
module csr_counter #(
  parameter int unsigned CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc_en,
  input  logic             we_lo,
  input  logic             we_hi,
  input  logic [31:0]      wd,
  output logic [CNT_W-1:0] value
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (we_lo || we_hi) begin
      if (we_lo) value[31:0] <= wd;
      if (we_hi) value[CNT_W-1:32] <= wd[CNT_W-33:0];
    end else if (inc_en) begin
      value <= value + CNT_W'(1);
    end
  end

endmodule

// File: rtl/csr_unit.sv
// Machine-mode CSR file: ID read port, EX read-modify-write commit, trap/mret
// sequencing, interrupt prioritisation and mcycle/minstret counters.
module csr_unit
  import csr_pkg::*;
#(
  parameter int unsigned CNT_W       = 64,
  parameter bit          VECTORED_EN = 1'b1,
  parameter logic [31:0] MTVEC_RESET = 32'h0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] csr_ra_id,
  output logic [31:0] csr_rd,
  output logic        csr_rd_illegal,
  input  logic        csr_we_ex,
  input  logic [1:0]  csr_op_ex,
  input  logic [11:0] csr_wa_ex,
  input  logic [31:0] csr_wd_ex,
  input  logic        retire,
  input  logic [2:0]  irq,
  input  logic        trap_valid,
  input  logic        trap_is_irq,
  input  logic [4:0]  trap_code,
  input  logic [31:0] trap_pc,
  input  logic        mret_valid,
  output logic [31:0] trap_target,
  output logic [31:0] mret_target,
  output logic        irq_req,
  output logic [4:0]  irq_code
);

  logic             mst_mie, mst_mpie;
  logic [2:0]       mie_q, mip_q;
  logic [31:0]      mtvec_q, mscratch_q;
  logic [29:0]      mepc_q;
  logic             mcause_irq;
  logic [4:0]       mcause_code;
  logic [CNT_W-1:0] mcycle, minstret;

  logic [31:0] mstatus_rd, mtvec_rd, mtvec_base;
  logic        vec_mode;

  always_comb begin
    mstatus_rd = '0;
    mstatus_rd[MSTATUS_MIE]  = mst_mie;
    mstatus_rd[MSTATUS_MPIE] = mst_mpie;
    mstatus_rd[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
  end

  assign vec_mode   = VECTORED_EN && mtvec_q[0];
  assign mtvec_base = {mtvec_q[31:2], 2'b00};
  assign mtvec_rd   = {mtvec_q[31:2], 1'b0, vec_mode};

  // Returns {unmapped, data} so the same decode serves ID reads and EX RMW.
  function automatic logic [32:0] read_csr(input logic [11:0] a);
    case (a)
      CSR_MSTATUS:   read_csr = {1'b0, mstatus_rd};
      CSR_MIE:       read_csr = {1'b0, irq_to_csr(mie_q)};
      CSR_MTVEC:     read_csr = {1'b0, mtvec_rd};
      CSR_MSCRATCH:  read_csr = {1'b0, mscratch_q};
      CSR_MEPC:      read_csr = {1'b0, mepc_q, 2'b00};
      CSR_MCAUSE:    read_csr = {1'b0, mcause_irq, 26'b0, mcause_code};
      CSR_MIP:       read_csr = {1'b0, irq_to_csr(mip_q)};
      CSR_MCYCLE:    read_csr = {1'b0, mcycle[31:0]};
      CSR_MCYCLEH:   read_csr = {1'b0, 32'(mcycle[CNT_W-1:32])};
      CSR_MINSTRET:  read_csr = {1'b0, minstret[31:0]};
      CSR_MINSTRETH: read_csr = {1'b0, 32'(minstret[CNT_W-1:32])};
      default:       read_csr = {1'b1, 32'h0};
    endcase
  endfunction

  logic [32:0] rd_id, rd_wa;
  logic [31:0] wval;
  logic        csr_wr;

  always_comb begin
    rd_id = read_csr(csr_ra_id);
    rd_wa = read_csr(csr_wa_ex);
    csr_rd         = rd_id[31:0];
    csr_rd_illegal = rd_id[32];
    case (csr_op_e'(csr_op_ex))
      CSR_OP_RW: wval = csr_wd_ex;
      CSR_OP_RS: wval = rd_wa[31:0] | csr_wd_ex;
      CSR_OP_RC: wval = rd_wa[31:0] & ~csr_wd_ex;
      default:   wval = rd_wa[31:0];
    endcase
  end

  // Trap and mret both outrank the EX commit, which is dropped outright.
  assign csr_wr = csr_we_ex && (csr_op_e'(csr_op_ex) != CSR_OP_NOP)
                  && !trap_valid && !mret_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mst_mie     <= 1'b0;
      mst_mpie    <= 1'b0;
      mie_q       <= '0;
      mip_q       <= '0;
      mtvec_q     <= MTVEC_RESET;
      mscratch_q  <= '0;
      mepc_q      <= '0;
      mcause_irq  <= 1'b0;
      mcause_code <= '0;
    end else begin
      mip_q <= irq;
      if (trap_valid) begin
        mepc_q      <= trap_pc[31:2];
        mcause_irq  <= trap_is_irq;
        mcause_code <= trap_code;
        mst_mpie    <= mst_mie;
        mst_mie     <= 1'b0;
      end else if (mret_valid) begin
        mst_mie  <= mst_mpie;
        mst_mpie <= 1'b1;
      end else if (csr_wr) begin
        case (csr_wa_ex)
          CSR_MSTATUS: begin
            mst_mie  <= wval[MSTATUS_MIE];
            mst_mpie <= wval[MSTATUS_MPIE];
          end
          CSR_MIE:      mie_q <= {wval[CAUSE_MEI], wval[CAUSE_MTI], wval[CAUSE_MSI]};
          CSR_MTVEC:    mtvec_q <= wval;
          CSR_MSCRATCH: mscratch_q <= wval;
          CSR_MEPC:     mepc_q <= wval[31:2];
          CSR_MCAUSE: begin
            mcause_irq  <= wval[31];
            mcause_code <= wval[4:0];
          end
          default: ;
        endcase
      end
    end
  end

  csr_counter #(.CNT_W(CNT_W)) u_mcycle (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc_en (1'b1),
    .we_lo  (csr_wr && csr_wa_ex == CSR_MCYCLE),
    .we_hi  (csr_wr && csr_wa_ex == CSR_MCYCLEH),
    .wd     (wval),
    .value  (mcycle)
  );

  csr_counter #(.CNT_W(CNT_W)) u_minstret (
    .clk    (clk),
    .rst_n  (rst_n),
    .inc_en (retire),
    .we_lo  (csr_wr && csr_wa_ex == CSR_MINSTRET),
    .we_hi  (csr_wr && csr_wa_ex == CSR_MINSTRETH),
    .wd     (wval),
    .value  (minstret)
  );

  logic [2:0] pend;
  assign pend    = mie_q & mip_q;
  assign irq_req = mst_mie && (|pend);

  always_comb begin
    if (pend[2])      irq_code = CAUSE_MEI;
    else if (pend[0]) irq_code = CAUSE_MSI;
    else if (pend[1]) irq_code = CAUSE_MTI;
    else              irq_code = '0;
  end

  assign trap_target = (vec_mode && trap_is_irq)
                       ? mtvec_base + {25'b0, trap_code, 2'b00}
                       : mtvec_base;
  assign mret_target = {mepc_q, 2'b00};

  logic unused_bits;
  assign unused_bits = ^{trap_pc[1:0], mtvec_q[1], rd_wa[32]};

endmodule

// File: tb/tb_csr_unit.sv
// Randomised and directed checks of csr_unit against a register-level
// reference model (plain 32/64-bit values with WARL masks).
module tb_csr_unit;

  localparam logic [31:0] TB_MTVEC = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] csr_ra_id, csr_wa_ex;
  logic [31:0] csr_rd, csr_wd_ex, trap_pc, trap_target, mret_target;
  logic        csr_rd_illegal, csr_we_ex, retire, trap_valid, trap_is_irq;
  logic        mret_valid, irq_req;
  logic [1:0]  csr_op_ex;
  logic [2:0]  irq;
  logic [4:0]  trap_code, irq_code;

  int total = 0;
  int bad   = 0;

  csr_unit #(.CNT_W(64), .VECTORED_EN(1'b1), .MTVEC_RESET(TB_MTVEC)) dut (
    .clk(clk), .rst_n(rst_n),
    .csr_ra_id(csr_ra_id), .csr_rd(csr_rd), .csr_rd_illegal(csr_rd_illegal),
    .csr_we_ex(csr_we_ex), .csr_op_ex(csr_op_ex), .csr_wa_ex(csr_wa_ex),
    .csr_wd_ex(csr_wd_ex), .retire(retire), .irq(irq),
    .trap_valid(trap_valid), .trap_is_irq(trap_is_irq), .trap_code(trap_code),
    .trap_pc(trap_pc), .mret_valid(mret_valid), .trap_target(trap_target),
    .mret_target(mret_target), .irq_req(irq_req), .irq_code(irq_code)
  );

  always #5 clk = ~clk;

  logic [11:0] addrs [13] = '{12'h300, 12'h304, 12'h305, 12'h340, 12'h341,
                              12'h342, 12'h344, 12'hB00, 12'hB80, 12'hB02,
                              12'hB82, 12'h7C0, 12'h301};

  // reference state, held as architectural register values
  logic [31:0] m_mstatus, m_mie, m_mtvec, m_mscratch, m_mepc, m_mcause, m_mip;
  logic [63:0] m_cyc, m_ins;

  task automatic model_reset();
    m_mstatus = 32'h1800; m_mie = 0; m_mtvec = TB_MTVEC & ~32'h2;
    m_mscratch = 0; m_mepc = 0; m_mcause = 0; m_mip = 0; m_cyc = 0; m_ins = 0;
  endtask

  function automatic logic [32:0] mread(input logic [11:0] a);
    case (a)
      12'h300: return {1'b0, m_mstatus};
      12'h304: return {1'b0, m_mie};
      12'h305: return {1'b0, m_mtvec};
      12'h340: return {1'b0, m_mscratch};
      12'h341: return {1'b0, m_mepc};
      12'h342: return {1'b0, m_mcause};
      12'h344: return {1'b0, m_mip};
      12'hB00: return {1'b0, m_cyc[31:0]};
      12'hB80: return {1'b0, m_cyc[63:32]};
      12'hB02: return {1'b0, m_ins[31:0]};
      12'hB82: return {1'b0, m_ins[63:32]};
      default: return {1'b1, 32'h0};
    endcase
  endfunction

  function automatic logic [4:0] exp_code();
    logic [31:0] p;
    p = m_mie & m_mip;
    if (p[11]) return 5'd11;
    if (p[3])  return 5'd3;
    if (p[7])  return 5'd7;
    return 5'd0;
  endfunction

  function automatic logic exp_req();
    return (m_mstatus[3] == 1'b1) && ((m_mie & m_mip) != 0);
  endfunction

  function automatic logic [31:0] exp_target();
    logic [31:0] base;
    base = m_mtvec & ~32'h3;
    if (m_mtvec[0] && trap_is_irq) return base + 32'(trap_code) * 4;
    return base;
  endfunction

  task automatic model_update();
    logic [32:0] r;
    logic [31:0] v;
    logic [63:0] nc, ni;
    logic [31:0] nst, nmie, ntv, nsc, nep, nca;
    nc = m_cyc + 64'd1;
    ni = m_ins + (retire ? 64'd1 : 64'd0);
    nst = m_mstatus; nmie = m_mie; ntv = m_mtvec; nsc = m_mscratch;
    nep = m_mepc; nca = m_mcause;
    if (trap_valid) begin
      nep = trap_pc & ~32'h3;
      nca = {trap_is_irq, 26'b0, trap_code};
      nst = 32'h1800 | ((m_mstatus & 32'h8) << 4);
    end else if (mret_valid) begin
      nst = 32'h1880 | ((m_mstatus & 32'h80) >> 4);
    end else if (csr_we_ex && csr_op_ex != 2'b00) begin
      r = mread(csr_wa_ex);
      case (csr_op_ex)
        2'b01:   v = csr_wd_ex;
        2'b10:   v = r[31:0] | csr_wd_ex;
        default: v = r[31:0] & ~csr_wd_ex;
      endcase
      case (csr_wa_ex)
        12'h300: nst = (v & 32'h88) | 32'h1800;
        12'h304: nmie = v & 32'h888;
        12'h305: ntv = v & ~32'h2;
        12'h340: nsc = v;
        12'h341: nep = v & ~32'h3;
        12'h342: nca = v & 32'h8000_001F;
        12'hB00: nc = {m_cyc[63:32], v};
        12'hB80: nc = {v, m_cyc[31:0]};
        12'hB02: ni = {m_ins[63:32], v};
        12'hB82: ni = {v, m_ins[31:0]};
        default: ;
      endcase
    end
    m_mip = (irq[2] ? 32'h800 : 0) | (irq[1] ? 32'h80 : 0) | (irq[0] ? 32'h8 : 0);
    m_mstatus = nst; m_mie = nmie; m_mtvec = ntv; m_mscratch = nsc;
    m_mepc = nep; m_mcause = nca; m_cyc = nc; m_ins = ni;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    csr_we_ex = 0; csr_op_ex = 0; csr_wa_ex = 0; csr_wd_ex = 0; retire = 0;
    trap_valid = 0; trap_is_irq = 0; trap_code = 0; trap_pc = 0; mret_valid = 0;
  endtask

  task automatic csr_write(input logic [11:0] a, input logic [1:0] op, input logic [31:0] d);
    csr_we_ex = 1; csr_op_ex = op; csr_wa_ex = a; csr_wd_ex = d;
    step();
    csr_we_ex = 0; csr_op_ex = 0;
  endtask

  task automatic test_reset();
    logic [32:0] e;
    rst_n = 0; irq = 0; csr_ra_id = 0;
    idle_inputs();
    model_reset();
    repeat (2) @(negedge clk);
    total++; if (irq_req !== 1'b0) begin bad++; $display("FAIL reset_irq_req got=%b exp=0", irq_req); end
    total++; if (irq_code !== 5'd0) begin bad++; $display("FAIL reset_irq_code got=%0d exp=0", irq_code); end
    total++; if (trap_target !== TB_MTVEC) begin bad++; $display("FAIL reset_trap_target got=%h exp=%h", trap_target, TB_MTVEC); end
    total++; if (mret_target !== 32'h0) begin bad++; $display("FAIL reset_mret_target got=%h exp=0", mret_target); end
    for (int i = 0; i < 13; i++) begin
      csr_ra_id = addrs[i];
      #1;
      e = mread(addrs[i]);
      total++;
      if (csr_rd !== e[31:0] || csr_rd_illegal !== e[32]) begin
        bad++;
        $display("FAIL reset_read_%h got=%h/%b exp=%h/%b", addrs[i], csr_rd, csr_rd_illegal, e[31:0], e[32]);
      end
    end
    csr_ra_id = 12'h300; #1;
    total++; if (csr_rd !== 32'h1800) begin bad++; $display("FAIL reset_mstatus got=%h exp=1800", csr_rd); end
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_mie_mstatus();
    csr_write(12'h304, 2'b10, 32'h888);
    csr_write(12'h304, 2'b11, 32'h8);
    csr_ra_id = 12'h304; #1;
    total++; if (csr_rd !== 32'h880) begin bad++; $display("FAIL mie_rs_rc got=%h exp=880", csr_rd); end
    csr_write(12'h300, 2'b01, 32'hFFFF_FFFF);
    csr_ra_id = 12'h300; #1;
    total++; if (csr_rd !== 32'h1888) begin bad++; $display("FAIL mstatus_warl got=%h exp=1888", csr_rd); end
  endtask

  task automatic test_irq_trap();
    csr_write(12'h305, 2'b01, 32'h1001);
    csr_write(12'h304, 2'b01, 32'h80);
    csr_write(12'h300, 2'b01, 32'h8);
    irq = 3'b010;
    step();
    total++; if (irq_req !== 1'b1) begin bad++; $display("FAIL irq_req_timer got=%b exp=1", irq_req); end
    total++; if (irq_code !== 5'd7) begin bad++; $display("FAIL irq_code_timer got=%0d exp=7", irq_code); end
    trap_valid = 1; trap_is_irq = 1; trap_code = 5'd7; trap_pc = 32'h200;
    #1;
    total++; if (trap_target !== 32'h101C) begin bad++; $display("FAIL trap_target_vec got=%h exp=101c", trap_target); end
    step();
    idle_inputs();
    csr_ra_id = 12'h341; #1;
    total++; if (csr_rd !== 32'h200) begin bad++; $display("FAIL trap_mepc got=%h exp=200", csr_rd); end
    csr_ra_id = 12'h342; #1;
    total++; if (csr_rd !== 32'h8000_0007) begin bad++; $display("FAIL trap_mcause got=%h exp=80000007", csr_rd); end
    csr_ra_id = 12'h300; #1;
    total++; if (csr_rd !== 32'h1880) begin bad++; $display("FAIL trap_mstatus got=%h exp=1880", csr_rd); end
    total++; if (mret_target !== 32'h200) begin bad++; $display("FAIL trap_mret_target got=%h exp=200", mret_target); end
    total++; if (irq_req !== 1'b0) begin bad++; $display("FAIL trap_masks_irq got=%b exp=0", irq_req); end
  endtask

  task automatic test_priority();
    csr_write(12'h304, 2'b01, 32'h888);
    csr_write(12'h300, 2'b10, 32'h8);
    irq = 3'b111;
    step();
    total++; if (irq_code !== 5'd11) begin bad++; $display("FAIL prio_all got=%0d exp=11", irq_code); end
    irq = 3'b011;
    step();
    total++; if (irq_code !== 5'd3) begin bad++; $display("FAIL prio_no_ext got=%0d exp=3", irq_code); end
    total++; if (irq_req !== exp_req()) begin bad++; $display("FAIL prio_req got=%b exp=%b", irq_req, exp_req()); end
    irq = 3'b000;
    step();
  endtask

  task automatic test_collision();
    trap_valid = 1; trap_is_irq = 0; trap_code = 5'd2; trap_pc = 32'h344;
    mret_valid = 1;
    csr_we_ex = 1; csr_op_ex = 2'b01; csr_wa_ex = 12'h341; csr_wd_ex = 32'hABCD0;
    step();
    idle_inputs();
    csr_ra_id = 12'h341; #1;
    total++; if (csr_rd !== 32'h344) begin bad++; $display("FAIL collide_mepc got=%h exp=344", csr_rd); end
    csr_ra_id = 12'h342; #1;
    total++; if (csr_rd !== 32'h2) begin bad++; $display("FAIL collide_mcause got=%h exp=2", csr_rd); end
    csr_ra_id = 12'h300; #1;
    total++; if (csr_rd !== m_mstatus) begin bad++; $display("FAIL collide_mstatus got=%h exp=%h", csr_rd, m_mstatus); end
  endtask

  task automatic test_counters();
    csr_write(12'hB00, 2'b01, 32'hFFFF_FFFF);
    csr_write(12'hB80, 2'b01, 32'h0);
    step();
    csr_ra_id = 12'hB80; #1;
    total++; if (csr_rd !== 32'h1) begin bad++; $display("FAIL mcycle_carry_hi got=%h exp=1", csr_rd); end
    csr_ra_id = 12'hB00; #1;
    total++; if (csr_rd !== 32'h0) begin bad++; $display("FAIL mcycle_carry_lo got=%h exp=0", csr_rd); end
    retire = 1;
    csr_write(12'hB02, 2'b01, 32'h55);
    retire = 0;
    csr_ra_id = 12'hB02; #1;
    total++; if (csr_rd !== 32'h55) begin bad++; $display("FAIL minstret_write_wins got=%h exp=55", csr_rd); end
    retire = 1;
    step();
    retire = 0;
    #1;
    total++; if (csr_rd !== 32'h56) begin bad++; $display("FAIL minstret_inc got=%h exp=56", csr_rd); end
  endtask

  task automatic test_random();
    logic [32:0] e;
    logic [11:0] a;
    for (int i = 0; i < 300; i++) begin
      csr_we_ex   = 1'($urandom_range(0, 1));
      csr_op_ex   = 2'($urandom);
      csr_wa_ex   = addrs[$urandom_range(0, 12)];
      csr_wd_ex   = $urandom;
      retire      = 1'($urandom_range(0, 1));
      irq         = 3'($urandom);
      trap_valid  = ($urandom_range(0, 7) == 0);
      mret_valid  = ($urandom_range(0, 7) == 0);
      trap_is_irq = 1'($urandom_range(0, 1));
      trap_code   = 5'($urandom);
      trap_pc     = $urandom;
      #1;
      total++;
      if (trap_target !== exp_target()) begin
        bad++; $display("FAIL rand_trap_target it=%0d got=%h exp=%h", i, trap_target, exp_target());
      end
      step();
      a = addrs[$urandom_range(0, 12)];
      csr_ra_id = a; #1;
      e = mread(a);
      total++;
      if (csr_rd !== e[31:0] || csr_rd_illegal !== e[32]) begin
        bad++; $display("FAIL rand_read_%h it=%0d got=%h/%b exp=%h/%b", a, i, csr_rd, csr_rd_illegal, e[31:0], e[32]);
      end
      total++;
      if (irq_req !== exp_req() || irq_code !== exp_code()) begin
        bad++; $display("FAIL rand_irq it=%0d got=%b/%0d exp=%b/%0d", i, irq_req, irq_code, exp_req(), exp_code());
      end
      total++;
      if (mret_target !== m_mepc) begin
        bad++; $display("FAIL rand_mret_target it=%0d got=%h exp=%h", i, mret_target, m_mepc);
      end
    end
    idle_inputs();
  endtask

  task automatic test_reset_midop();
    csr_write(12'h340, 2'b01, 32'hDEAD_BEEF);
    #2;
    rst_n = 0;
    #1;
    model_reset();
    csr_ra_id = 12'h340; #1;
    total++; if (csr_rd !== 32'h0) begin bad++; $display("FAIL midreset_mscratch got=%h exp=0", csr_rd); end
    csr_ra_id = 12'hB00; #1;
    total++; if (csr_rd !== 32'h0) begin bad++; $display("FAIL midreset_mcycle got=%h exp=0", csr_rd); end
    @(negedge clk);
    rst_n = 1;
    step();
    #1;
    total++; if (csr_rd !== 32'h1) begin bad++; $display("FAIL first_inc_after_reset got=%h exp=1", csr_rd); end
  endtask

  initial begin
    test_reset();
    test_mie_mstatus();
    test_irq_trap();
    test_priority();
    test_collision();
    test_counters();
    test_random();
    test_reset_midop();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
